spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal values 2..255.
REQ-002 SHALL have parameter LEN_W, default 4: width of the byte-count field.
REQ-003 SHALL have port clk, input, 1: system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: transaction request; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: synchronous transaction cancel.
REQ-007 SHALL have port tx_len, input, LEN_W: number of bytes in the transaction; sampled with start.
REQ-008 SHALL have port tx_data, input, 8: next byte to transmit; sampled when tx_ack is pulsed.
REQ-009 SHALL have port tx_ack, output, 1: one-cycle pulse when tx_data is loaded.
REQ-010 SHALL have port rx_data, output, 8: last fully received byte.
REQ-011 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data is updated.
REQ-012 SHALL have port busy, output, 1: high from start acceptance until return to IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-014 SHALL have ports spi_cs_n (output, 1), spi_sclk (output, 1) and spi_mosi (output, 1), plus spi_miso (input, 1).
REQ-015 SHALL have port work_en, output, 1: equals ~spi_cs_n; it enables the downstream deserializer.
REQ-016 SHALL have port work_pulse, output, 1: one-cycle strobe, co-timed with each miso sample.

Function
REQ-017 SHALL implement a 4-state FSM (IDLE, SETUP, XFER, HOLD) and use SPI mode 0 (CPOL=0, CPHA=0).
REQ-018 In IDLE with start=1 and tx_len!=0, SHALL in the same edge latch tx_len, load tx_data, pulse tx_ack, drive cs_n=0 and busy=1, and enter SETUP.
REQ-019 SHALL ignore start when tx_len=0 (no outputs change) and ignore start in any non-IDLE state.
REQ-020 SETUP SHALL last CLK_DIV cycles with sclk=0 and mosi=bit 0 of the loaded byte; the FSM then enters XFER.
REQ-021 In XFER, a divider counting 0..CLK_DIV-1 SHALL toggle sclk at terminal count, giving an SCLK period of 2*CLK_DIV clk cycles.
REQ-022 On each sclk rising toggle, the controller SHALL sample spi_miso into the rx bit at the current bit index and pulse work_pulse for one cycle.
REQ-023 On each sclk falling toggle, the controller SHALL advance the 3-bit bit index and drive mosi with the next bit.
REQ-024 On the 8th falling toggle of a byte, the controller SHALL update rx_data, pulse rx_valid, and decrement the remaining-byte count.
REQ-025 At that same 8th falling toggle, if bytes remain, the controller SHALL load tx_data, pulse tx_ack, and continue XFER with no SCLK gap; otherwise it SHALL enter HOLD.
REQ-026 HOLD SHALL last CLK_DIV cycles with sclk=0; then cs_n=1, busy=0, done pulses for one cycle, and the FSM enters IDLE.
REQ-027 A new start SHALL be accepted at the earliest on the cycle after done.
REQ-028 With abort=1 in any non-IDLE state, the next edge SHALL force cs_n=1, sclk=0, busy=0, IDLE state, and no done or rx_valid pulse; a partially received byte is discarded.
REQ-029 abort and start asserted together in IDLE: abort SHALL win and start is ignored.
REQ-030 rx_data SHALL hold its value between rx_valid pulses.
REQ-031 tx_len=2^LEN_W-1 SHALL transfer exactly that many bytes; the byte counter SHALL NOT wrap.

Reset
REQ-032 Reset SHALL force IDLE, cs_n=1, sclk=0, mosi=0, rx_data=8'h00, and tx_ack, rx_valid, done, busy, work_pulse=0, and zero all counters.
REQ-033 Reset asserted mid-transaction SHALL take effect immediately and produce no done pulse.

Configuration
REQ-034 With SPI_MSB_FIRST_EN defined, both the transmitted and received bit order SHALL be MSB first (bit index 7 down to 0).
REQ-035 Without SPI_MSB_FIRST_EN, bit order SHALL be LSB first (bit index 0 up to 7), matching the existing 1-to-8 receiver; all timing SHALL be identical in both builds.

Verification
REQ-036 CLK_DIV=4, tx_len=1, tx_data=8'hA5, miso looped to mosi -> 8 SCLK periods of 8 clk cycles each, rx_data=8'hA5, one rx_valid, done 4 cycles after the last fall, 1 tx_ack.
REQ-037 tx_len=3, tx_data sequence 8'h01/8'h02/8'h03 on tx_ack -> 24 contiguous SCLK periods, 3 rx_valid pulses, 3 tx_ack pulses, cs_n low continuously.
REQ-038 tx_len=0 with start=1 -> busy stays 0, cs_n stays 1, no pulses.
REQ-039 abort after the 3rd rising edge of byte 1 -> cs_n=1 on the next cycle, no rx_valid, no done; a following start with tx_len=1 completes normally.
REQ-040 rst_n low mid-byte 2 of 3 -> all outputs at reset values asynchronously; after release, IDLE accepts a new start.
REQ-041 SPI_MSB_FIRST_EN build, tx_data=8'h80 -> mosi high only during the first bit period; loopback rx_data=8'h80.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master controller with byte streaming, abort and a work-enable strobe for the downstream deserializer.
// Build option: define SPI_MSB_FIRST_EN for MSB-first bit order; the default build is LSB-first.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       tx_data,
    output logic             tx_ack,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             work_en,
    output logic             work_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

`ifdef SPI_MSB_FIRST_EN
    localparam logic [2:0] FIRST_IDX = 3'd7;
    localparam logic [2:0] LAST_IDX  = 3'd0;
`else
    localparam logic [2:0] FIRST_IDX = 3'd0;
    localparam logic [2:0] LAST_IDX  = 3'd7;
`endif

    // Walks the bit index in the configured shift direction.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
`ifdef SPI_MSB_FIRST_EN
        return idx - 3'd1;
`else
        return idx + 3'd1;
`endif
    endfunction

    state_t           state_r;
    logic [7:0]       div_r;
    logic [2:0]       bit_idx_r;
    logic [LEN_W-1:0] len_r;
    logic [7:0]       tx_byte_r;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_data_r;
    logic             sclk_r;
    logic             cs_n_r;
    logic             mosi_r;
    logic             busy_r;
    logic             tx_ack_r;
    logic             rx_valid_r;
    logic             done_r;
    logic             work_pulse_r;
    logic             work_en_r;
    logic             div_tc_s;

    assign div_tc_s = (div_r == DIV_LAST);

    // Transaction FSM: divider, bit/byte sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            div_r        <= 8'd0;
            bit_idx_r    <= FIRST_IDX;
            len_r        <= LEN_ZERO;
            tx_byte_r    <= 8'h00;
            rx_shift_r   <= 8'h00;
            rx_data_r    <= 8'h00;
            sclk_r       <= 1'b0;
            cs_n_r       <= 1'b1;
            mosi_r       <= 1'b0;
            busy_r       <= 1'b0;
            tx_ack_r     <= 1'b0;
            rx_valid_r   <= 1'b0;
            done_r       <= 1'b0;
            work_pulse_r <= 1'b0;
            work_en_r    <= 1'b0;
        end else begin
            tx_ack_r     <= 1'b0;
            rx_valid_r   <= 1'b0;
            done_r       <= 1'b0;
            work_pulse_r <= 1'b0;
            if (abort && (state_r != ST_IDLE)) begin
                // Cancel drops the partial byte and returns silently.
                state_r    <= ST_IDLE;
                div_r      <= 8'd0;
                bit_idx_r  <= FIRST_IDX;
                len_r      <= LEN_ZERO;
                rx_shift_r <= 8'h00;
                sclk_r     <= 1'b0;
                cs_n_r     <= 1'b1;
                work_en_r  <= 1'b0;
                mosi_r     <= 1'b0;
                busy_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start && !abort && (tx_len != LEN_ZERO)) begin
                            state_r   <= ST_SETUP;
                            div_r     <= 8'd0;
                            bit_idx_r <= FIRST_IDX;
                            len_r     <= tx_len;
                            tx_byte_r <= tx_data;
                            mosi_r    <= tx_data[FIRST_IDX];
                            tx_ack_r  <= 1'b1;
                            cs_n_r    <= 1'b0;
                            work_en_r <= 1'b1;
                            busy_r    <= 1'b1;
                        end else begin
                            div_r <= 8'd0;
                        end
                    end
                    ST_SETUP: begin
                        if (div_tc_s) begin
                            state_r <= ST_XFER;
                            div_r   <= 8'd0;
                        end else begin
                            div_r <= div_r + 8'd1;
                        end
                    end
                    ST_XFER: begin
                        if (!div_tc_s) begin
                            div_r <= div_r + 8'd1;
                        end else if (!sclk_r) begin
                            div_r                 <= 8'd0;
                            sclk_r                <= 1'b1;
                            rx_shift_r[bit_idx_r] <= spi_miso;
                            work_pulse_r          <= 1'b1;
                        end else begin
                            div_r  <= 8'd0;
                            sclk_r <= 1'b0;
                            if (bit_idx_r == LAST_IDX) begin
                                rx_data_r  <= rx_shift_r;
                                rx_valid_r <= 1'b1;
                                len_r      <= len_r - LEN_ONE;
                                bit_idx_r  <= FIRST_IDX;
                                // Next byte starts on this same fall, so SCLK never pauses.
                                if (len_r != LEN_ONE) begin
                                    tx_byte_r <= tx_data;
                                    mosi_r    <= tx_data[FIRST_IDX];
                                    tx_ack_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_HOLD;
                                    mosi_r  <= 1'b0;
                                end
                            end else begin
                                bit_idx_r <= next_idx(bit_idx_r);
                                mosi_r    <= tx_byte_r[next_idx(bit_idx_r)];
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (div_tc_s) begin
                            state_r   <= ST_IDLE;
                            div_r     <= 8'd0;
                            cs_n_r    <= 1'b1;
                            work_en_r <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            div_r <= div_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        div_r     <= 8'd0;
                        sclk_r    <= 1'b0;
                        cs_n_r    <= 1'b1;
                        work_en_r <= 1'b0;
                        mosi_r    <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ack     = tx_ack_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign spi_cs_n   = cs_n_r;
    assign spi_sclk   = sclk_r;
    assign spi_mosi   = mosi_r;
    assign work_en    = work_en_r;
    assign work_pulse = work_pulse_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl (CLK_DIV=4, LEN_W=4) with optional MISO loopback.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] tx_len = 4'd0;
    logic [7:0] tx_data;
    logic       tx_ack, rx_valid, busy, done;
    logic [7:0] rx_data;
    logic       spi_cs_n, spi_sclk, spi_mosi, spi_miso;
    logic       work_en, work_pulse;

    logic       loop_en = 1'b1;
    logic       miso_val = 1'b0;
    logic [7:0] tx_bytes [0:15];
    int         tx_idx = 0;

    int n_checks = 0;
    int n_fail = 0;

    // monitor statistics
    int cyc = 0;
    int rise_cnt, first_rise, last_rise, last_fall, busy_cyc;
    int ack_cnt, rx_n, done_cnt, done_cyc, wp_cnt, wp_bad, cs_rise, bit_k, mosi_n;
    logic [7:0] rx_bytes [0:15];
    logic [7:0] mosi_bytes [0:15];
    logic [7:0] mosi_sh;
    logic sclk_prev = 1'b0, cs_prev = 1'b1, busy_prev = 1'b0;

    assign tx_data  = tx_bytes[tx_idx[3:0]];
    assign spi_miso = loop_en ? spi_mosi : miso_val;

    spi_master_ctrl #(.CLK_DIV(4), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .tx_len(tx_len), .tx_data(tx_data), .tx_ack(tx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .work_en(work_en), .work_pulse(work_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (busy && !busy_prev) busy_cyc = cyc;
        if (spi_sclk && !sclk_prev) begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt == 1) first_rise = cyc;
            last_rise = cyc;
            if (!work_pulse) wp_bad = wp_bad + 1;
`ifdef SPI_MSB_FIRST_EN
            mosi_sh = {mosi_sh[6:0], spi_mosi};
`else
            mosi_sh = {spi_mosi, mosi_sh[7:1]};
`endif
            bit_k = bit_k + 1;
            if (bit_k == 8) begin
                if (mosi_n < 16) mosi_bytes[mosi_n] = mosi_sh;
                mosi_n = mosi_n + 1;
                bit_k = 0;
            end
        end
        if (!spi_sclk && sclk_prev) last_fall = cyc;
        if (work_pulse) wp_cnt = wp_cnt + 1;
        if (tx_ack) begin
            ack_cnt = ack_cnt + 1;
            tx_idx = tx_idx + 1;
        end
        if (rx_valid) begin
            if (rx_n < 16) rx_bytes[rx_n] = rx_data;
            rx_n = rx_n + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (spi_cs_n && !cs_prev) cs_rise = cs_rise + 1;
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
        busy_prev = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        @(posedge clk);
        #1;
        rise_cnt = 0; first_rise = 0; last_rise = 0; last_fall = 0; busy_cyc = 0;
        ack_cnt = 0; rx_n = 0; done_cnt = 0; done_cyc = 0; wp_cnt = 0; wp_bad = 0;
        cs_rise = 0; bit_k = 0; mosi_n = 0; mosi_sh = 8'h00; tx_idx = 0;
    endtask

    task automatic launch(input logic [3:0] len);
        clear_stats();
        @(negedge clk);
        tx_len = len;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_eq(tag, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
        clear_stats();
        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check_eq("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("rst_flags", {26'd0, busy, done, tx_ack, rx_valid, work_pulse, work_en}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte A5 with loopback
        tx_bytes[0] = 8'hA5;
        launch(4'd1);
        wait_idle(500, "t1_timeout");
        check_eq("t1_rises", rise_cnt, 32'd8);
        check_eq("t1_first_rise_lat", first_rise - busy_cyc, 32'd8);
        check_eq("t1_sclk_span", last_rise - first_rise, 32'd56);
        check_eq("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        check_eq("t1_rx_valid_cnt", rx_n, 32'd1);
        check_eq("t1_tx_ack_cnt", ack_cnt, 32'd1);
        check_eq("t1_done_cnt", done_cnt, 32'd1);
        check_eq("t1_done_lat", done_cyc - last_fall, 32'd4);
        check_eq("t1_work_pulse_cnt", wp_cnt, 32'd8);
        check_eq("t1_work_pulse_align", wp_bad, 32'd0);
        check_eq("t1_mosi_byte", {24'd0, mosi_bytes[0]}, 32'hA5);
        check_eq("t1_cs_n_end", {31'd0, spi_cs_n}, 32'd1);
        repeat (20) @(negedge clk);
        check_eq("t1_rx_hold", {24'd0, rx_data}, 32'hA5);

        // Three contiguous bytes
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03;
        launch(4'd3);
        wait_idle(1000, "t2_timeout");
        check_eq("t2_rises", rise_cnt, 32'd24);
        check_eq("t2_sclk_span", last_rise - first_rise, 32'd184);
        check_eq("t2_rx_valid_cnt", rx_n, 32'd3);
        check_eq("t2_rx0", {24'd0, rx_bytes[0]}, 32'h01);
        check_eq("t2_rx1", {24'd0, rx_bytes[1]}, 32'h02);
        check_eq("t2_rx2", {24'd0, rx_bytes[2]}, 32'h03);
        check_eq("t2_tx_ack_cnt", ack_cnt, 32'd3);
        check_eq("t2_cs_n_rises", cs_rise, 32'd1);
        check_eq("t2_done_cnt", done_cnt, 32'd1);

        // MISO held high, MOSI all zeros
        loop_en = 1'b0; miso_val = 1'b1;
        tx_bytes[0] = 8'h00;
        launch(4'd1);
        wait_idle(500, "t3_timeout");
        check_eq("t3_rx_data", {24'd0, rx_data}, 32'hFF);
        check_eq("t3_mosi_byte", {24'd0, mosi_bytes[0]}, 32'h00);
        loop_en = 1'b1; miso_val = 1'b0;

        // Zero length start is ignored
        clear_stats();
        @(negedge clk);
        tx_len = 4'd0; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        check_eq("t4_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("t4_pulses", ack_cnt + rx_n + done_cnt + wp_cnt, 32'd0);

        // Abort and start together in IDLE: abort wins
        @(negedge clk);
        tx_len = 4'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_ack_cnt", ack_cnt, 32'd0);

        // Abort after third rising edge of byte 1
        tx_bytes[0] = 8'h5A;
        launch(4'd1);
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt >= 3) break;
            @(negedge clk);
        end
        check_eq("t6_reached_rise3", {31'd0, (rise_cnt >= 3)}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t6_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_sclk", {31'd0, spi_sclk}, 32'd0);
        repeat (100) @(negedge clk);
        check_eq("t6_no_rx_valid", rx_n, 32'd0);
        check_eq("t6_no_done", done_cnt, 32'd0);
        check_eq("t6_rx_hold", {24'd0, rx_data}, 32'hFF);
        tx_bytes[0] = 8'h3C;
        launch(4'd1);
        wait_idle(500, "t6b_timeout");
        check_eq("t6b_rx_data", {24'd0, rx_data}, 32'h3C);
        check_eq("t6b_done_cnt", done_cnt, 32'd1);

        // Async reset mid byte 2 of 3
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
        launch(4'd3);
        for (int i = 0; i < 500; i++) begin
            if (rise_cnt >= 11) break;
            @(negedge clk);
        end
        check_eq("t7_reached_byte2", {31'd0, (rise_cnt >= 11)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("t7_sclk_mosi", {30'd0, spi_sclk, spi_mosi}, 32'd0);
        check_eq("t7_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("t7_flags", {26'd0, busy, done, tx_ack, rx_valid, work_pulse, work_en}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("t7_no_done", done_cnt, 32'd0);
        tx_bytes[0] = 8'h77;
        launch(4'd1);
        wait_idle(500, "t7b_timeout");
        check_eq("t7b_rx_data", {24'd0, rx_data}, 32'h77);
        check_eq("t7b_done_cnt", done_cnt, 32'd1);

        // Maximum length: 15 bytes, no counter wrap
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h10 + 8'(i);
        launch(4'd15);
        wait_idle(3000, "t8_timeout");
        check_eq("t8_rx_valid_cnt", rx_n, 32'd15);
        check_eq("t8_tx_ack_cnt", ack_cnt, 32'd15);
        check_eq("t8_rx_last", {24'd0, rx_bytes[14]}, 32'h1E);
        check_eq("t8_rises", rise_cnt, 32'd120);
        check_eq("t8_done_cnt", done_cnt, 32'd1);

`ifdef SPI_MSB_FIRST_EN
        tx_bytes[0] = 8'h80;
        launch(4'd1);
        wait_idle(500, "t9_timeout");
        check_eq("t9_rx_data", {24'd0, rx_data}, 32'h80);
        check_eq("t9_mosi_byte", {24'd0, mosi_bytes[0]}, 32'h80);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
